// File: rtl/if_prefetch.sv
// if_prefetch: sequential instruction fetch with a small prefetch queue.
// Single outstanding memory request; a redirect flushes the queue.
module if_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ok,
  input  logic [ILEN-1:0] mem_dt,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_pc,
  input  logic            is_ready,
  output logic            is_valid,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] is
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [ILEN-1:0] is_mem [DEPTH];

  logic            push;
  logic            pop;
  logic            not_full;
  logic [XLEN-1:0] jmp_tgt;

  assign jmp_tgt  = {jmp_pc[XLEN-1:2], 2'b00};
  assign not_full = cnt_q < (AW+1)'(DEPTH);
  assign is_valid = cnt_q != '0;
  assign pop      = is_valid && is_ready && !jmp;
  assign pc       = is_valid ? pc_mem[rd_q] : '0;
  assign is       = is_valid ? is_mem[rd_q] : '0;
  assign mem_req  = req_q;
  assign mem_addr = addr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (jmp) begin
          fetch_pc_d = jmp_tgt;
        end else if (not_full) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (jmp) begin
          fetch_pc_d = jmp_tgt;
          if (mem_ok) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (mem_ok) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
          req_d      = 1'b0;
          state_d    = IDLE;
        end
      end
      DROP: begin
        // the response still owed to the old stream is swallowed here
        if (jmp) fetch_pc_d = jmp_tgt;
        if (mem_ok) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (jmp) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q] <= fetch_pc_q;
      is_mem[wr_q] <= mem_dt;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: memory responder, expected-entry scoreboard
// and decode-side monitor, driven by per-scenario tasks.
module tb_if_prefetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ok = 1'b0;
  logic [31:0] mem_dt = '0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_pc = '0;
  logic        is_ready = 1'b0;
  logic        is_valid;
  logic [31:0] pc;
  logic [31:0] is;

  if_prefetch dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ok(mem_ok), .mem_dt(mem_dt),
    .jmp(jmp), .jmp_pc(jmp_pc),
    .is_ready(is_ready), .is_valid(is_valid),
    .pc(pc), .is(is)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] is;
  } ent_t;

  ent_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          wcnt = 0;
  int          req_cnt = 0;
  int          npop = 0;
  bit          outst = 0;
  bit          drop = 0;
  bit          mark = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] cur_addr = '0;
  logic [31:0] mark_pc = '0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h07B06093;
      32'h4:   return 32'h0E906113;
      32'h8:   return 32'h3E70E213;
      default: return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endcase
  endfunction

  // memory: answers each request after lat idle cycles
  always @(posedge clk) begin
    #1;
    mem_ok = 1'b0;
    if (!rst) begin
      outst = 0;
      wcnt  = 0;
    end else begin
      if (mem_req && !outst) begin
        outst = 1;
        wcnt = 0;
        req_cnt++;
        cur_addr = mem_addr;
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL req_addr: got %h want %h", mem_addr, exp_addr);
        end
      end else if (outst) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== cur_addr) begin
          errors++;
          $display("FAIL req_hold: req %b addr %h want 1 %h",
                   mem_req, mem_addr, cur_addr);
        end
      end
      if (outst) begin
        if (wcnt == lat) begin
          mem_ok = 1'b1;
          outst = 0;
          if (drop) begin
            drop = 0;
            mem_dt = 32'hDEADBEEF;
          end else begin
            mem_dt = memval(exp_addr);
            exp_q.push_back({exp_addr, mem_dt});
            exp_addr += 32'd4;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // decode side: every accepted entry must match the scoreboard head
  always @(negedge clk) begin
    ent_t e;
    if (rst && is_valid && is_ready && !jmp) begin
      npop++;
      checks++;
      if (mark) begin
        mark_pc = pc;
        mark = 0;
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_extra: got pc %h is %h want none", pc, is);
      end else begin
        e = exp_q.pop_front();
        if (pc !== e.pc || is !== e.is) begin
          errors++;
          $display("FAIL pop_entry: got %h/%h want %h/%h",
                   pc, is, e.pc, e.is);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_addr = '0;
    drop = 0;
    mark = 0;
    req_cnt = 0;
    npop = 0;
  endtask

  task automatic do_reset(input int l, input bit rdy);
    rst = 1'b0;
    jmp = 1'b0;
    is_ready = rdy;
    lat = l;
    step(2);
    clear_model();
    rst = 1'b1;
  endtask

  task automatic do_jmp(input logic [31:0] a);
    jmp = 1'b1;
    jmp_pc = a;
    exp_q.delete();
    exp_addr = a & ~32'h3;
    drop = mem_req && !mem_ok;
    mark = 1;
    step();
    jmp = 1'b0;
  endtask

  task automatic wait_q(input int n, input string nm);
    int t = 0;
    while (exp_q.size() < n && t < 60) begin
      step();
      t++;
    end
    checks++;
    if (exp_q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d entries want %0d", nm, exp_q.size(), n);
    end
  endtask

  task automatic wait_pop(input string nm, input logic [31:0] want);
    int t = 0;
    int n0 = npop;
    while (npop == n0 && t < 60) begin
      step();
      t++;
    end
    checks++;
    if (npop == n0) begin
      errors++;
      $display("FAIL %s_timeout: got no pop want pc %h", nm, want);
    end else if (mark_pc !== want) begin
      errors++;
      $display("FAIL %s_first_pc: got %h want %h", nm, mark_pc, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(2);
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || is_valid !== 1'b0 ||
        pc !== '0 || is !== '0) begin
      errors++;
      $display("FAIL reset_out: got req %b addr %h v %b pc %h is %h want zeros",
               mem_req, mem_addr, is_valid, pc, is);
    end
  endtask

  task automatic test_sequential();
    int t = 0;
    do_reset(1, 1'b1);
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: got %b %h want 1 00000000", mem_req, mem_addr);
    end
    while (npop < 3 && t < 40) begin
      step();
      t++;
    end
    checks++;
    if (npop < 3) begin
      errors++;
      $display("FAIL seq_pops: got %0d want 3", npop);
    end
  endtask

  task automatic test_backpressure();
    do_reset(0, 1'b0);
    step(20);
    checks++;
    if (req_cnt != 4 || mem_req !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL full_stall: got reqs %0d req %b pc %h want 4 0 00000000",
               req_cnt, mem_req, pc);
    end
    is_ready = 1'b1;
    step();
    is_ready = 1'b0;
    checks++;
    if (pc !== 32'h4 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL after_pop: got pc %h req %b want 00000004 0", pc, mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10 || req_cnt != 5) begin
      errors++;
      $display("FAIL refill_req: got %b %h n %0d want 1 00000010 5",
               mem_req, mem_addr, req_cnt);
    end
  endtask

  task automatic test_redirect_idle();
    do_reset(0, 1'b0);
    wait_q(2, "rd_idle");
    step();
    do_jmp(32'h103);
    checks++;
    if (is_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle_flush: got v %b req %b want 0 0", is_valid, mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rd_idle_req: got %b %h want 1 00000100", mem_req, mem_addr);
    end
    is_ready = 1'b1;
    wait_pop("rd_idle", 32'h100);
  endtask

  task automatic test_redirect_wait();
    int t = 0;
    do_reset(3, 1'b1);
    while (!(mem_req && mem_addr == 32'h8) && t < 60) begin
      step();
      t++;
    end
    checks++;
    if (!(mem_req && mem_addr == 32'h8)) begin
      errors++;
      $display("FAIL rd_wait_timeout: got %b %h want 1 00000008", mem_req, mem_addr);
    end
    step();
    do_jmp(32'h200);
    checks++;
    if (is_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      errors++;
      $display("FAIL rd_wait_drop: got v %b req %b addr %h want 0 1 00000008",
               is_valid, mem_req, mem_addr);
    end
    step(2);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait_idle: got req %b want 0", mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL rd_wait_req: got %b %h want 1 00000200", mem_req, mem_addr);
    end
    wait_pop("rd_wait", 32'h200);
  endtask

  task automatic test_simultaneous();
    do_reset(0, 1'b0);
    wait_q(3, "simul");
    checks++;
    if (mem_ok !== 1'b1 || is_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_setup: got ok %b v %b want 1 1", mem_ok, is_valid);
    end
    is_ready = 1'b1;
    do_jmp(32'h300);
    checks++;
    if (is_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL simul_flush: got v %b req %b want 0 0", is_valid, mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL simul_req: got %b %h want 1 00000300", mem_req, mem_addr);
    end
    wait_pop("simul", 32'h300);
  endtask

  task automatic test_async_reset();
    int t = 0;
    do_reset(3, 1'b0);
    while (!(exp_q.size() >= 1 && mem_req && !mem_ok) && t < 60) begin
      step();
      t++;
    end
    checks++;
    if (is_valid !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup: got v %b req %b want 1 1", is_valid, mem_req);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || is_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_clear: got req %b v %b want 0 0", mem_req, is_valid);
    end
    clear_model();
    step(2);
    rst = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL arst_restart: got %b %h want 1 00000000", mem_req, mem_addr);
    end
    step(4);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_idle();
    test_redirect_wait();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
